// File: rtl/fetch_queue.sv
// Instruction prefetch queue.
// Fetches sequential words into a DEPTH-entry FIFO of {word, pc} pairs, one
// request outstanding at a time. A redirect flushes the queue and restarts
// fetch. The head entry and a lookahead entry are exposed, together with a
// hint that the head's rd feeds the next instruction's rs1.
module fetch_queue #(
  parameter int              DEPTH    = 2,
  parameter int              PC_W     = 30,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [31:0]                mem_rdata,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       deq,
  output logic                       ir_valid,
  output logic [31:0]                ir,
  output logic [PC_W-1:0]            ir_pc,
  output logic                       next_valid,
  output logic [31:0]                next_ir,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       raw_hint
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, next_ptr;
  logic [CNT_W-1:0] count_q;
  logic [PC_W-1:0]  fetch_pc, req_pc;
  logic [31:0]      word_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic             push, pop, issue;

  // Fetch FSM next-state, request and push decode.
  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Single outstanding request, so any free entry is a free slot.
        mem_req = (count_q < CNT_W'(DEPTH)) && !redirect;
        if (mem_req && mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          push    = !redirect;
          state_d = IDLE;
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      push    = 1'b0;
    end
  end

  assign issue    = mem_req && mem_gnt;
  assign pop      = deq && (count_q != '0) && !redirect;
  assign mem_addr = 32'({fetch_pc, 2'b00});

  // State, pointers, occupancy and fetch address; redirect overrides push/pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count_q  <= '0;
        fetch_pc <= redirect_pc;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + PC_W'(1);
          req_pc   <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count_q <= count_q + CNT_W'(1);
        else if (!push && pop) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Queue storage: written at the tail on push.
  // NOTE: the storage is cleared on reset so the head never shows stale
  // words from before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      word_mem[wr_ptr] <= mem_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

  assign next_ptr   = rd_ptr + PTR_W'(1);
  assign count      = count_q;
  assign ir_valid   = !rst && (count_q != '0);
  assign next_valid = !rst && (count_q >= CNT_W'(2));
  assign ir         = word_mem[rd_ptr];
  assign ir_pc      = pc_mem[rd_ptr];
  assign next_ir    = word_mem[next_ptr];

  // Forwarding hint: head produces rd, lookahead consumes it as rs1.
  always_comb begin
    logic head_writes, next_reads;
    head_writes = (ir[6:0] == OPC_OP)    || (ir[6:0] == OPC_OP_IMM) ||
                  (ir[6:0] == OPC_LOAD)  || (ir[6:0] == OPC_AUIPC)  ||
                  (ir[6:0] == OPC_LUI);
    next_reads  = !((next_ir[6:0] == OPC_JAL) || (next_ir[6:0] == OPC_LUI) ||
                    (next_ir[6:0] == OPC_AUIPC));
    raw_hint    = ir_valid && next_valid && (ir[11:7] != 5'd0) &&
                  (ir[11:7] == next_ir[19:15]) && head_writes && next_reads;
  end

endmodule
